// File: rtl/led_bank_arbiter_pkg.sv
// Shared types and constants for the LED bank arbiter.
package led_arb_pkg;

  localparam int LED_W = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    OWNED    = 2'd1,
    HANDOVER = 2'd2
  } arb_state_e;

  // Slot counter must hold 0..hold inclusive.
  function automatic int cnt_width(input int hold);
    return $clog2(hold + 1);
  endfunction

endpackage

// File: rtl/led_bank_arbiter_if.sv
// Request/data/grant bundle between the display producers and the LED bank arbiter.
interface led_bank_arbiter_if #(
  parameter int NREQ = 4
);
  localparam int IW = $clog2(NREQ);

  logic                               tick;
  logic                               freeze;
  logic [NREQ-1:0]                    req;
  logic [led_arb_pkg::LED_W*NREQ-1:0] data;
  logic [NREQ-1:0]                    grant;
  logic [IW-1:0]                      owner;
  logic                               busy;
  logic [led_arb_pkg::LED_W-1:0]      leds;

  modport master (
    output tick, freeze, req, data,
    input  grant, owner, busy, leds
  );

  modport slave (
    input  tick, freeze, req, data,
    output grant, owner, busy, leds
  );

endinterface

// File: rtl/led_bank_arbiter_rr_pick.sv
// Round-robin picker: first requester at or above pointer, wrapping past NREQ-1.
module rr_pick #(
  parameter  int NREQ = 4,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   pointer,
  output logic            found,
  output logic [IW-1:0]   index
);

  always_comb begin : pick
    int j;
    found = 1'b0;
    index = '0;
    j     = 0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(pointer) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!found && req[j]) begin
        found = 1'b1;
        index = IW'(j);
      end
    end
  end

endmodule

// File: rtl/led_bank_arbiter.sv
// Shares the 8-LED bank between NREQ display requesters with round-robin
// fairness and a minimum hold time measured in tick strobes.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | no owner, leds dark
// OWNED    | grant[owner] high, leds follow owner's data one cycle late
// HANDOVER | one dead cycle between owners, rr pointer already advanced
module led_bank_arbiter
  import led_arb_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int HOLD_TICKS = 4
) (
  input logic               clk,
  input logic               reset_n,
  led_bank_arbiter_if.slave bus
);

  localparam int                IW       = $clog2(NREQ);
  localparam int                CW       = cnt_width(HOLD_TICKS);
  localparam logic [CW-1:0]     HOLD_CNT = CW'(HOLD_TICKS);

  arb_state_e        state_q, state_d;
  logic [CW-1:0]     slot_q, slot_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [LED_W-1:0]  leds_q, leds_d;

  logic              pick_found;
  logic [IW-1:0]     pick_idx;
  logic [NREQ-1:0]   pick_onehot;
  logic [NREQ-1:0]   others;
  logic [IW-1:0]     next_ptr;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req     (bus.req),
    .pointer (ptr_q),
    .found   (pick_found),
    .index   (pick_idx)
  );

  assign pick_onehot = NREQ'(1) << pick_idx;
  assign next_ptr    = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + IW'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      slot_q  <= '0;
      ptr_q   <= '0;
      owner_q <= '0;
      grant_q <= '0;
      leds_q  <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      leds_q  <= leds_d;
    end
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    grant_d = grant_q;
    leds_d  = leds_q;
    others  = bus.req;
    others[owner_q] = 1'b0;

    case (state_q)
      IDLE: begin
        grant_d = '0;
        leds_d  = '0;
        if (pick_found) begin
          state_d = OWNED;
          grant_d = pick_onehot;
          owner_d = pick_idx;
          slot_d  = '0;
        end
      end

      OWNED: begin
        leds_d = bus.data[int'(owner_q)*LED_W +: LED_W];
        if (bus.tick && !bus.freeze && slot_q != HOLD_CNT)
          slot_d = slot_q + CW'(1);
        // A release coinciding with a preempt takes the same path.
        if (!bus.req[owner_q] ||
            (slot_q == HOLD_CNT && !bus.freeze && (|others))) begin
          state_d = HANDOVER;
          grant_d = '0;
          ptr_d   = next_ptr;
        end
      end

      HANDOVER: begin
        grant_d = '0;
        leds_d  = '0;
        if (pick_found) begin
          state_d = OWNED;
          grant_d = pick_onehot;
          owner_d = pick_idx;
          slot_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.grant = grant_q;
  assign bus.owner = owner_q;
  assign bus.busy  = (state_q == OWNED);
  assign bus.leds  = leds_q;

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Scoreboarded bench for led_bank_arbiter: scenarios queue cycle-stamped expectations.
module tb_led_bank_arbiter;
  import led_arb_pkg::*;

  localparam int NREQ = 4;
  localparam int HOLD = 4;
  localparam logic [7:0] D0 = 8'hA5;
  localparam logic [7:0] D1 = 8'h3C;
  localparam logic [7:0] D2 = 8'h96;
  localparam logic [7:0] D3 = 8'h5A;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;

  led_bank_arbiter_if #(.NREQ(NREQ)) bus ();

  led_bank_arbiter #(.NREQ(NREQ), .HOLD_TICKS(HOLD)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic [3:0] grant;
    logic [7:0] leds;
    logic       busy;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic expect_at(input int ofs, input logic [3:0] g, input logic [7:0] l,
                           input logic b, input string nm);
    exp_t e;
    e.at = cyc + ofs; e.grant = g; e.leds = l; e.busy = b; e.name = nm;
    sb.push_back(e);
  endtask

  // Scoreboard: pop entries whose cycle has arrived and compare against outputs.
  always @(negedge clk) begin
    int i;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].at <= cyc) begin
        n_vec++;
        if (sb[i].at < cyc) begin
          n_err++;
          $display("FAIL %s: entry for cycle %0d not compared, now cycle %0d",
                   sb[i].name, sb[i].at, cyc);
        end else if (bus.grant !== sb[i].grant || bus.leds !== sb[i].leds ||
                     bus.busy !== sb[i].busy) begin
          n_err++;
          $display("FAIL %s @%0d: grant=%b leds=%h busy=%b, expected grant=%b leds=%h busy=%b",
                   sb[i].name, cyc, bus.grant, bus.leds, bus.busy,
                   sb[i].grant, sb[i].leds, sb[i].busy);
        end
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic set_data();
    bus.data = {D3, D2, D1, D0};
  endtask

  task automatic apply_reset();
    @(negedge clk);
    bus.req    = '0;
    bus.tick   = 1'b0;
    bus.freeze = 1'b0;
    reset_n    = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // Ten-cycle tick period; returns at the negedge right after the tick was sampled.
  task automatic do_tick();
    repeat (9) @(negedge clk);
    bus.tick = 1'b1;
    @(negedge clk);
    bus.tick = 1'b0;
  endtask

  task automatic test_reset();
    set_data();
    bus.tick   = 1'b0;
    bus.freeze = 1'b0;
    bus.req    = 4'b1111;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (bus.grant !== 4'b0000) begin
      n_err++; $display("FAIL reset_grant: got %b expected 0000", bus.grant);
    end
    n_vec++;
    if (bus.leds !== 8'h00) begin
      n_err++; $display("FAIL reset_leds: got %h expected 00", bus.leds);
    end
    n_vec++;
    if (bus.busy !== 1'b0) begin
      n_err++; $display("FAIL reset_busy: got %b expected 0", bus.busy);
    end
    n_vec++;
    if (bus.owner !== 2'd0) begin
      n_err++; $display("FAIL reset_owner: got %0d expected 0", bus.owner);
    end
    reset_n = 1'b1;
    expect_at(1, 4'b0001, 8'h00, 1'b1, "rst_first_grant");
    expect_at(2, 4'b0001, D0,    1'b1, "rst_first_leds");
    repeat (3) @(negedge clk);
  endtask

  task automatic test_release();
    bus.req = 4'b0010;
    expect_at(1, 4'b0000, D0,    1'b0, "rel_handover");
    expect_at(2, 4'b0010, 8'h00, 1'b1, "rel_new_grant");
    expect_at(3, 4'b0010, D1,    1'b1, "rel_new_leds");
    repeat (4) @(negedge clk);
    n_vec++;
    if (bus.owner !== 2'd1) begin
      n_err++; $display("FAIL rel_owner: got %0d expected 1", bus.owner);
    end
  endtask

  task automatic test_data_follow();
    bus.data[15:8] = 8'hC3;
    expect_at(1, 4'b0010, 8'hC3, 1'b1, "data_follow_new");
    @(negedge clk);
    set_data();
    expect_at(1, 4'b0010, D1, 1'b1, "data_follow_back");
    @(negedge clk);
  endtask

  task automatic test_idle();
    bus.req = 4'b0000;
    expect_at(1, 4'b0000, D1,    1'b0, "idle_handover");
    expect_at(2, 4'b0000, 8'h00, 1'b0, "idle_dark");
    expect_at(5, 4'b0000, 8'h00, 1'b0, "idle_stay");
    repeat (6) @(negedge clk);
    n_vec++;
    if (bus.owner !== 2'd1) begin
      n_err++; $display("FAIL idle_owner_kept: got %0d expected 1", bus.owner);
    end
  endtask

  task automatic test_preempt();
    apply_reset();
    bus.req = 4'b0101;
    expect_at(1, 4'b0001, 8'h00, 1'b1, "pre_first");
    for (int k = 1; k <= 4; k++) begin
      do_tick();
      if (k < 4) begin
        expect_at(1, 4'b0001, D0, 1'b1, "pre_hold0");
      end else begin
        expect_at(1, 4'b0000, D0,    1'b0, "pre_handover0");
        expect_at(2, 4'b0100, 8'h00, 1'b1, "pre_grant2");
        expect_at(3, 4'b0100, D2,    1'b1, "pre_leds2");
      end
    end
    for (int k = 1; k <= 4; k++) begin
      do_tick();
      if (k < 4) begin
        expect_at(1, 4'b0100, D2, 1'b1, "pre_hold2");
      end else begin
        expect_at(1, 4'b0000, D2,    1'b0, "pre_handover2");
        expect_at(2, 4'b0001, 8'h00, 1'b1, "pre_back_to0");
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_freeze();
    apply_reset();
    bus.req = 4'b0101;
    for (int k = 1; k <= 4; k++) do_tick();
    bus.freeze = 1'b1;
    expect_at(1, 4'b0001, D0, 1'b1, "frz_blocks");
    for (int k = 0; k < 3; k++) begin
      do_tick();
      expect_at(1, 4'b0001, D0, 1'b1, "frz_hold");
    end
    repeat (5) @(negedge clk);
    bus.freeze = 1'b0;
    expect_at(1, 4'b0000, D0,    1'b0, "frz_release_ho");
    expect_at(2, 4'b0100, 8'h00, 1'b1, "frz_release_grant");
    repeat (3) @(negedge clk);
  endtask

  task automatic test_saturate();
    apply_reset();
    bus.req = 4'b1000;
    expect_at(1, 4'b1000, 8'h00, 1'b1, "sat_first");
    for (int k = 1; k <= 20; k++) begin
      do_tick();
      if (k % 5 == 0) expect_at(1, 4'b1000, D3, 1'b1, "sat_hold");
    end
    @(negedge clk);
    n_vec++;
    if (dut.slot_q !== 3'd4) begin
      n_err++; $display("FAIL sat_counter: got %0d expected 4", dut.slot_q);
    end
    bus.req = 4'b1010;
    expect_at(1, 4'b0000, D3,    1'b0, "sat_preempt_ho");
    expect_at(2, 4'b0010, 8'h00, 1'b1, "sat_preempt_grant");
    repeat (4) @(negedge clk);
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_vec++;
    if (bus.grant !== 4'b0000) begin
      n_err++; $display("FAIL async_grant: got %b expected 0000", bus.grant);
    end
    n_vec++;
    if (bus.leds !== 8'h00) begin
      n_err++; $display("FAIL async_leds: got %h expected 00", bus.leds);
    end
    n_vec++;
    if (bus.busy !== 1'b0) begin
      n_err++; $display("FAIL async_busy: got %b expected 0", bus.busy);
    end
    n_vec++;
    if (bus.owner !== 2'd0) begin
      n_err++; $display("FAIL async_owner: got %0d expected 0", bus.owner);
    end
    @(negedge clk);
    reset_n = 1'b1;
    expect_at(1, 4'b0010, 8'h00, 1'b1, "post_rst_grant");
    expect_at(2, 4'b0010, D1,    1'b1, "post_rst_leds");
    repeat (3) @(negedge clk);
  endtask

  initial begin
    bus.req    = '0;
    bus.tick   = 1'b0;
    bus.freeze = 1'b0;
    set_data();
    test_reset();
    test_release();
    test_data_follow();
    test_idle();
    test_preempt();
    test_freeze();
    test_saturate();
    test_async_reset();
    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_drain: %0d expectations never compared", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
